// File: rtl/mips_regfile_dbg.sv
// MIPS general-purpose register file: two registered read ports, one write port with write-first
// bypass, hardwired $zero, plus a valid/ready debug port that streams every register in order.
module mips_regfile_dbg #(
  parameter int unsigned N_BITS    = 32,
  parameter int unsigned N_REGS    = 32,
  parameter int unsigned ADDR_BITS = $clog2(N_REGS)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [ADDR_BITS-1:0] i_read_reg_1,
  input  logic [ADDR_BITS-1:0] i_read_reg_2,
  input  logic [ADDR_BITS-1:0] i_write_reg,
  input  logic [N_BITS-1:0]    i_write_data,
  input  logic                 i_reg_write,
  input  logic                 i_dump_start,
  input  logic                 i_dump_ready,
  output logic [N_BITS-1:0]    o_read_data_1,
  output logic [N_BITS-1:0]    o_read_data_2,
  output logic                 o_dump_valid,
  output logic [ADDR_BITS-1:0] o_dump_addr,
  output logic [N_BITS-1:0]    o_dump_data,
  output logic                 o_dump_busy,
  output logic                 o_dump_done
);

  typedef enum logic [1:0] {StIdle, StSend, StDone} dump_state_e;

  dump_state_e          state_q, state_d;
  logic [N_BITS-1:0]    regs_q [N_REGS];
  logic [N_BITS-1:0]    rd_data_1_q, rd_data_2_q;
  logic [N_BITS-1:0]    dump_data_q, dump_data_d;
  logic [ADDR_BITS-1:0] dump_addr_q, dump_addr_d;
  logic [ADDR_BITS-1:0] dump_next_addr;
  logic [N_BITS-1:0]    rd_val_1, rd_val_2, dump_next_val;
  logic                 wr_en, dump_accept, dump_last;

  // True for addresses backed by real storage; $zero and out-of-range addresses read as 0.
  function automatic logic addr_live(input logic [ADDR_BITS-1:0] a);
    return (a != '0) && (32'(a) < N_REGS);
  endfunction

  assign wr_en          = i_valid && i_reg_write && addr_live(i_write_reg);
  assign dump_next_addr = dump_addr_q + ADDR_BITS'(1);
  assign dump_accept    = (state_q == StSend) && i_dump_ready;
  assign dump_last      = (32'(dump_addr_q) == N_REGS - 1);

  // Write-first: a same-cycle write to the looked-up register wins over the stored value.
  always_comb begin
    rd_val_1      = '0;
    rd_val_2      = '0;
    dump_next_val = '0;
    if (addr_live(i_read_reg_1)) begin
      rd_val_1 = (wr_en && i_write_reg == i_read_reg_1) ? i_write_data : regs_q[i_read_reg_1];
    end
    if (addr_live(i_read_reg_2)) begin
      rd_val_2 = (wr_en && i_write_reg == i_read_reg_2) ? i_write_data : regs_q[i_read_reg_2];
    end
    if (addr_live(dump_next_addr)) begin
      dump_next_val = (wr_en && i_write_reg == dump_next_addr) ? i_write_data
                                                               : regs_q[dump_next_addr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < int'(N_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[i_write_reg] <= i_write_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_data_1_q <= '0;
      rd_data_2_q <= '0;
    end else if (i_valid) begin
      rd_data_1_q <= rd_val_1;
      rd_data_2_q <= rd_val_2;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= StIdle;
      dump_addr_q <= '0;
      dump_data_q <= '0;
    end else begin
      state_q     <= state_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
    end
  end

  // Address/data only move on an accepted beat, so a stalled beat is held stable.
  always_comb begin
    state_d     = state_q;
    dump_addr_d = dump_addr_q;
    dump_data_d = dump_data_q;
    unique case (state_q)
      StIdle: begin
        if (i_dump_start) begin
          state_d     = StSend;
          dump_addr_d = '0;
          dump_data_d = '0;
        end
      end
      StSend: begin
        if (dump_accept) begin
          if (dump_last) begin
            state_d = StDone;
          end else begin
            dump_addr_d = dump_next_addr;
            dump_data_d = dump_next_val;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign o_read_data_1 = rd_data_1_q;
  assign o_read_data_2 = rd_data_2_q;
  assign o_dump_valid  = (state_q == StSend);
  assign o_dump_addr   = dump_addr_q;
  assign o_dump_data   = dump_data_q;
  assign o_dump_busy   = (state_q != StIdle);
  assign o_dump_done   = (state_q == StDone);

endmodule

// File: tb/tb_mips_regfile_dbg.sv
// Bench for mips_regfile_dbg: directed scenarios plus randomized read/write traffic checked
// against an array model of the register file.
module tb_mips_regfile_dbg;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_valid = 1'b0;
  logic [4:0]  i_read_reg_1 = '0, i_read_reg_2 = '0, i_write_reg = '0;
  logic [31:0] i_write_data = '0;
  logic        i_reg_write = 1'b0, i_dump_start = 1'b0, i_dump_ready = 1'b0;
  logic [31:0] o_read_data_1, o_read_data_2, o_dump_data;
  logic        o_dump_valid, o_dump_busy, o_dump_done;
  logic [4:0]  o_dump_addr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model [32];
  logic [31:0] exp_rd1 = '0, exp_rd2 = '0;
  logic [4:0]  beat_addr [$];
  logic [31:0] beat_data [$];
  logic [31:0] beat_exp  [$];

  mips_regfile_dbg #(.N_BITS(32), .N_REGS(32)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .i_read_reg_1  (i_read_reg_1),
    .i_read_reg_2  (i_read_reg_2),
    .i_write_reg   (i_write_reg),
    .i_write_data  (i_write_data),
    .i_reg_write   (i_reg_write),
    .i_dump_start  (i_dump_start),
    .i_dump_ready  (i_dump_ready),
    .o_read_data_1 (o_read_data_1),
    .o_read_data_2 (o_read_data_2),
    .o_dump_valid  (o_dump_valid),
    .o_dump_addr   (o_dump_addr),
    .o_dump_data   (o_dump_data),
    .o_dump_busy   (o_dump_busy),
    .o_dump_done   (o_dump_done)
  );

  always #5 i_clk = ~i_clk;

  // Value a lookup of address a sees this cycle, including a same-cycle write.
  function automatic logic [31:0] lookup(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (i_valid && i_reg_write && i_write_reg == a) return i_write_data;
    return model[a];
  endfunction

  // One clock: advance the model in step with the DUT, return #1 after the edge.
  task automatic tick();
    logic [31:0] e1, e2;
    logic        do_w;
    e1   = lookup(i_read_reg_1);
    e2   = lookup(i_read_reg_2);
    do_w = i_valid && i_reg_write && i_write_reg != 0;
    @(posedge i_clk);
    if (i_reset) begin
      foreach (model[i]) model[i] = 32'h0;
      exp_rd1 = 32'h0;
      exp_rd2 = 32'h0;
    end else begin
      if (do_w) model[i_write_reg] = i_write_data;
      if (i_valid) begin
        exp_rd1 = e1;
        exp_rd2 = e2;
      end
    end
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    i_valid = 1'b1; i_reg_write = 1'b1; i_write_reg = a; i_write_data = d;
    tick();
    i_valid = 1'b0; i_reg_write = 1'b0;
  endtask

  // Runs one dump. mode 0: ready held high; mode 1: ready alternates and r3 is written while
  // beat 3 is stalled. abort_addr >= 0 asserts reset when that beat is on the port.
  task automatic drive_dump(input int mode, input int abort_addr, output int n_done,
                            output int cycles, output int busy_low);
    int idx;
    logic [31:0] cur_exp;
    logic wrote;
    beat_addr.delete(); beat_data.delete(); beat_exp.delete();
    n_done = 0; cycles = 0; busy_low = 0; idx = 0; wrote = 1'b0;
    i_dump_start = 1'b1;
    cur_exp = 32'h0;
    tick();
    cycles = 1;
    i_dump_start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (o_dump_done) begin
        n_done++;
        break;
      end
      if (!o_dump_busy) busy_low++;
      i_valid = 1'b0; i_reg_write = 1'b0;
      if (abort_addr >= 0 && idx == abort_addr) begin
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        return;
      end
      i_dump_ready = (mode == 0) ? 1'b1 : (c % 2 == 0);
      if (mode == 1 && !i_dump_ready && idx == 3 && !wrote) begin
        i_valid = 1'b1; i_reg_write = 1'b1; i_write_reg = 5'd3; i_write_data = 32'hCAFEF00D;
        wrote = 1'b1;
      end
      if (o_dump_valid && i_dump_ready) begin
        beat_addr.push_back(o_dump_addr);
        beat_data.push_back(o_dump_data);
        beat_exp.push_back(cur_exp);
        if (idx < 31) cur_exp = lookup(5'(idx + 1));
        idx++;
      end
      tick();
      cycles++;
    end
    i_valid = 1'b0; i_reg_write = 1'b0; i_dump_ready = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    i_reset = 1'b0;
    n_tests++;
    if (o_read_data_1 !== 0 || o_read_data_2 !== 0 || o_dump_valid !== 0 || o_dump_addr !== 0 ||
        o_dump_data !== 0 || o_dump_busy !== 0 || o_dump_done !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs: rd1=%h rd2=%h v=%b a=%0d d=%h busy=%b done=%b required all 0",
               o_read_data_1, o_read_data_2, o_dump_valid, o_dump_addr, o_dump_data,
               o_dump_busy, o_dump_done);
    end
    write_reg(5'd5, 32'hDEADBEEF);
    i_valid = 1'b1; i_read_reg_1 = 5'd5;
    tick();
    n_tests++;
    if (o_read_data_1 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL pre_reset_r5: got %h required DEADBEEF", o_read_data_1);
    end
    i_valid = 1'b0;
    i_reset = 1'b1; tick(); i_reset = 1'b0;
    i_valid = 1'b1; i_read_reg_1 = 5'd5;
    tick();
    i_valid = 1'b0;
    n_tests++;
    if (o_read_data_1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_clears_r5: got %h required 0", o_read_data_1);
    end
  endtask

  task automatic test_write_read_bypass();
    i_valid = 1'b1; i_reg_write = 1'b1; i_write_reg = 5'd7; i_write_data = 32'h12345678;
    i_read_reg_1 = 5'd7; i_read_reg_2 = 5'd7;
    tick();
    i_reg_write = 1'b0; i_valid = 1'b0;
    n_tests++;
    if (o_read_data_1 !== 32'h12345678 || o_read_data_2 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL bypass_r7: rd1=%h rd2=%h required 12345678", o_read_data_1, o_read_data_2);
    end
  endtask

  task automatic test_zero_hold();
    i_valid = 1'b1; i_reg_write = 1'b1; i_write_reg = 5'd0; i_write_data = 32'hFFFFFFFF;
    i_read_reg_1 = 5'd0; i_read_reg_2 = 5'd0;
    tick();
    i_reg_write = 1'b0;
    tick();
    n_tests++;
    if (o_read_data_1 !== 32'h0 || o_read_data_2 !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_reg: rd1=%h rd2=%h required 0", o_read_data_1, o_read_data_2);
    end
    i_valid = 1'b0; i_read_reg_1 = 5'd7; i_read_reg_2 = 5'd7;
    tick();
    n_tests++;
    if (o_read_data_1 !== 32'h0 || o_read_data_2 !== 32'h0) begin
      n_fail++;
      $display("FAIL hold_invalid: rd1=%h rd2=%h required 0", o_read_data_1, o_read_data_2);
    end
  endtask

  task automatic test_random_rw();
    int errs = 0;
    for (int i = 0; i < 300; i++) begin
      i_valid      = ($urandom_range(0, 3) != 0);
      i_reg_write  = $urandom_range(0, 1);
      i_write_reg  = 5'($urandom_range(0, 31));
      i_write_data = $urandom;
      i_read_reg_1 = ($urandom_range(0, 3) == 0) ? i_write_reg : 5'($urandom_range(0, 31));
      i_read_reg_2 = ($urandom_range(0, 3) == 0) ? i_read_reg_1 : 5'($urandom_range(0, 31));
      tick();
      n_tests++;
      if (o_read_data_1 !== exp_rd1 || o_read_data_2 !== exp_rd2) begin
        n_fail++;
        errs++;
        if (errs < 10)
          $display("FAIL random_rw[%0d]: rd1=%h rd2=%h required %h %h", i, o_read_data_1,
                   o_read_data_2, exp_rd1, exp_rd2);
      end
    end
    i_valid = 1'b0; i_reg_write = 1'b0;
  endtask

  task automatic test_dump();
    int n_done, cycles, busy_low, errs;
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i * 32'h11));
    drive_dump(0, -1, n_done, cycles, busy_low);
    n_tests++;
    if (beat_addr.size() != 32 || n_done != 1 || cycles != 33 || busy_low != 0) begin
      n_fail++;
      $display("FAIL dump_shape: beats=%0d done=%0d cycles=%0d busy_low=%0d required 32 1 33 0",
               beat_addr.size(), n_done, cycles, busy_low);
    end
    errs = 0;
    foreach (beat_addr[k]) begin
      n_tests++;
      if (beat_addr[k] !== 5'(k) || beat_data[k] !== 32'(k * 32'h11)) begin
        n_fail++;
        errs++;
        if (errs < 10)
          $display("FAIL dump_beat[%0d]: addr=%0d data=%h required %0d %h", k, beat_addr[k],
                   beat_data[k], k, 32'(k * 32'h11));
      end
    end
    tick();
    n_tests++;
    if (o_dump_done !== 1'b0 || o_dump_busy !== 1'b0 || o_dump_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dump_after_done: done=%b busy=%b valid=%b required 0 0 0", o_dump_done,
               o_dump_busy, o_dump_valid);
    end
  endtask

  task automatic test_backpressure();
    int n_done, cycles, busy_low, errs;
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i * 32'h11));
    drive_dump(1, -1, n_done, cycles, busy_low);
    n_tests++;
    if (beat_addr.size() != 32 || n_done != 1) begin
      n_fail++;
      $display("FAIL bp_shape: beats=%0d done=%0d required 32 1", beat_addr.size(), n_done);
    end
    n_tests++;
    if (beat_data.size() > 3 && beat_data[3] !== 32'h33) begin
      n_fail++;
      $display("FAIL bp_stalled_beat3: got %h required 00000033", beat_data[3]);
    end
    errs = 0;
    foreach (beat_addr[k]) begin
      n_tests++;
      if (beat_addr[k] !== 5'(k) || beat_data[k] !== beat_exp[k]) begin
        n_fail++;
        errs++;
        if (errs < 10)
          $display("FAIL bp_beat[%0d]: addr=%0d data=%h required %0d %h", k, beat_addr[k],
                   beat_data[k], k, beat_exp[k]);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_dump();
    int n_done, cycles, busy_low, errs;
    drive_dump(0, 10, n_done, cycles, busy_low);
    n_tests++;
    if (o_dump_valid !== 1'b0 || o_dump_busy !== 1'b0 || o_dump_done !== 1'b0 || n_done != 0) begin
      n_fail++;
      $display("FAIL abort_state: valid=%b busy=%b done=%b seen_done=%0d required 0 0 0 0",
               o_dump_valid, o_dump_busy, o_dump_done, n_done);
    end
    tick();
    n_tests++;
    if (o_dump_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: done=%b required 0", o_dump_done);
    end
    drive_dump(0, -1, n_done, cycles, busy_low);
    n_tests++;
    if (beat_addr.size() != 32 || n_done != 1) begin
      n_fail++;
      $display("FAIL redump_shape: beats=%0d done=%0d required 32 1", beat_addr.size(), n_done);
    end
    errs = 0;
    foreach (beat_addr[k]) begin
      n_tests++;
      if (beat_addr[k] !== 5'(k) || beat_data[k] !== 32'h0) begin
        n_fail++;
        errs++;
        if (errs < 10)
          $display("FAIL redump_beat[%0d]: addr=%0d data=%h required %0d 0", k, beat_addr[k],
                   beat_data[k], k);
      end
    end
    tick();
  endtask

  initial begin
    foreach (model[i]) model[i] = 32'h0;
    test_reset();
    test_write_read_bypass();
    test_zero_hold();
    test_random_rw();
    test_dump();
    test_backpressure();
    test_reset_mid_dump();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
